// File: rtl/wr_en_register_pkg.sv
// wr_en_register_pkg
//   Shared constants for the write-enabled storage register.
//   WR_EN_REG_W_DEFAULT : default data width used when an instance does not
//                         override W.
package wr_en_register_pkg;

  localparam int unsigned WR_EN_REG_W_DEFAULT = 16;

endpackage : wr_en_register_pkg

// File: rtl/wr_en_register_reg_bit.sv
// reg_bit
//   One storage bit: a D flop with asynchronous active-low reset, a load
//   enable and a per-bit reset value.
// Ports
//   clk        in  1  clock, rising-edge active
//   rst_n      in  1  asynchronous active-low reset
//   i_en       in  1  load enable, sampled at rising clk
//   i_d        in  1  data to load
//   i_rst_val  in  1  value taken while rst_n=0 (a constant tie-off)
//   o_q        out 1  stored bit, straight from the flop
module reg_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_d,
  input  logic i_rst_val,
  output logic o_q
);

  logic r_q;

  // An X/Z enable falls through the if and holds the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= i_rst_val;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : reg_bit

// File: rtl/wr_en_register.sv
// wr_en_register
//   W-bit storage register with synchronous write enable. Loads d_i on a
//   rising clk edge when wr_en=1, otherwise holds. Asynchronous active-low
//   reset forces RESET_VAL. Built as W independent reg_bit flops so each
//   bit maps one-to-one onto a library enable flop.
// Parameters
//   W          data width (>=1)
//   RESET_VAL  value forced onto d_o while rst_n=0
// Ports
//   clk    in  1  clock, rising-edge active
//   rst_n  in  1  asynchronous active-low reset
//   wr_en  in  1  write enable, sampled at rising clk
//   d_i    in  W  write data, sampled at rising clk
//   d_o    out W  stored value, driven directly from flops
module wr_en_register
  import wr_en_register_pkg::*;
#(
  parameter int unsigned       W         = WR_EN_REG_W_DEFAULT,
  parameter logic [W-1:0]      RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] d_o
);

  logic [W-1:0] w_q;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      reg_bit u_bit (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (wr_en),
        .i_d       (d_i[gi]),
        .i_rst_val (RESET_VAL[gi]),
        .o_q       (w_q[gi])
      );
    end
  endgenerate

  // No logic between the flops and the output: d_o cannot follow d_i/wr_en.
  assign d_o = w_q;

endmodule : wr_en_register

// File: tb/tb_wr_en_register.sv
// tb_wr_en_register
//   Scoreboard bench for wr_en_register. Three instances share clk, rst_n and
//   wr_en: 8-bit with reset value 0x00, 8-bit with reset value 0x5A, and a
//   1-bit instance. The stimulus process applies inputs 3 units before each
//   rising edge and pushes the expected post-edge contents into a queue; the
//   monitor pops and compares 2 units after each edge, re-checks mid-cycle
//   that nothing moved, and checks the reset value shortly after rst_n falls.
module tb_wr_en_register;

  localparam logic [7:0] RV8  = 8'h00;
  localparam logic [7:0] RV5A = 8'h5A;
  localparam logic       RV1  = 1'b0;

  typedef struct packed {
    logic [7:0] e8;
    logic [7:0] e5a;
    logic       e1;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] d_i8;
  logic       d_i1;
  logic [7:0] d_o8;
  logic [7:0] d_o5a;
  logic       d_o1;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;

  // Reference contents: what each register holds right now.
  logic [7:0] m8;
  logic [7:0] m5a;
  logic       m1;

  wr_en_register #(.W(8), .RESET_VAL(RV8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .d_i(d_i8), .d_o(d_o8)
  );

  wr_en_register #(.W(8), .RESET_VAL(RV5A)) u_dut5a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .d_i(d_i8), .d_o(d_o5a)
  );

  wr_en_register #(.W(1), .RESET_VAL(RV1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .d_i(d_i1), .d_o(d_o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // One clock cycle of stimulus. Between edges d_i/wr_en are scrambled to
  // show d_o ignores them; optionally rst_n is pulled low mid-cycle. At
  // edge-3 the real inputs (and rst_n for the coming edge) are applied and
  // the expected post-edge contents are queued.
  task automatic step(input logic we, input logic [7:0] d, input logic rst_at_edge,
                      input bit assert_mid);
    @(posedge clk);
    #3;
    wr_en = 1'($urandom); d_i8 = 8'($urandom); d_i1 = 1'($urandom);
    #1;
    wr_en = 1'b1; d_i8 = 8'($urandom); d_i1 = ~d_i1;
    #1;
    if (assert_mid) begin
      rst_n = 1'b0;
      m8 = RV8; m5a = RV5A; m1 = RV1;
    end
    #2;
    rst_n = rst_at_edge;
    wr_en = we;
    d_i8  = d;
    d_i1  = d[0];
    if (!rst_at_edge) begin
      m8 = RV8; m5a = RV5A; m1 = RV1;
    end else if (we) begin
      m8 = d; m5a = d; m1 = d[0];
    end
    exp_q.push_back('{e8: m8, e5a: m5a, e1: m1});
  endtask

  // Post-edge and mid-cycle monitor.
  initial begin
    exp_t cur;
    bit   have;
    have = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        cur  = exp_q.pop_front();
        have = 1'b1;
        check("edge_w8",   d_o8,         cur.e8);
        check("edge_rv5a", d_o5a,        cur.e5a);
        check("edge_w1",   {7'b0, d_o1}, {7'b0, cur.e1});
      end
      #4;
      if (have && rst_n === 1'b1) begin
        check("mid_w8",   d_o8,         cur.e8);
        check("mid_rv5a", d_o5a,        cur.e5a);
        check("mid_w1",   {7'b0, d_o1}, {7'b0, cur.e1});
      end
    end
  end

  // Asynchronous reset monitor: reset value must appear without a clock edge.
  initial begin
    forever begin
      @(negedge rst_n);
      #1;
      check("rst_w8",   d_o8,         RV8);
      check("rst_rv5a", d_o5a,        RV5A);
      check("rst_w1",   {7'b0, d_o1}, {7'b0, RV1});
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b1;
    wr_en = 1'b1;
    d_i8  = 8'hAA;
    d_i1  = 1'b0;
    m8 = 'x; m5a = 'x; m1 = 'x;

    // 1: reset mid-cycle with a pending write, hold across edges, release.
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    // 2: write 0, then hold against d_i=5.
    step(1'b1, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd5, 1'b1, 1'b0);
    // 3: back-to-back writes.
    step(1'b1, 8'd5,  1'b1, 1'b0);
    step(1'b1, 8'd10, 1'b1, 1'b0);
    // 4: hold against d_i=20, then rewrite the same value.
    step(1'b0, 8'd20, 1'b1, 1'b0);
    step(1'b1, 8'd10, 1'b1, 1'b0);
    // 5: reset between edges while holding 10, released before the edge.
    step(1'b0, 8'd33, 1'b1, 1'b1);
    // 6: all-ones then all-zeros.
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'hC3, 1'b1, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 8'($urandom), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 29) == 0));
    end
    step(1'b1, 8'h81, 1'b1, 1'b0);

    // Let the monitor consume the last expectation, then confirm the drain.
    @(posedge clk);
    #4;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d entries required=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_wr_en_register
